// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - opcode, condition and field constants plus decoded-instruction type
package risc_pkg;

    localparam logic [3:0] OP_ADI  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_NAND = 4'b0010;

    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_Z      = 2'b01;
    localparam logic [1:0] COND_C      = 2'b10;
    localparam logic [1:0] COND_CARRY  = 2'b11;

    localparam int OPC_LSB  = 12;
    localparam int RA_LSB   = 9;
    localparam int RB_LSB   = 6;
    localparam int RC_LSB   = 3;
    localparam int COMP_BIT = 2;
    localparam int COND_LSB = 0;
    localparam int IMM_LSB  = 0;

    typedef enum logic [1:0] {
        CLS_ADI,
        CLS_ADD,
        CLS_NAND,
        CLS_OTHER
    } op_class_e;

    typedef struct packed {
        logic [3:0] opcode;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [2:0] rc;
        logic       comp;
        logic [1:0] cond;
        logic [5:0] imm6;
        logic [2:0] dest;
        logic       use_carry;
        logic       wr_c;
        logic       wr_z;
        logic       illegal;
    } dec_t;

    function automatic op_class_e op_class(input logic [3:0] op);
        case (op)
            OP_ADI:  return CLS_ADI;
            OP_ADD:  return CLS_ADD;
            OP_NAND: return CLS_NAND;
            default: return CLS_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/risc_instr_decode.sv
// rtl/risc_instr_decode.sv - combinational instruction word to field/flag decode
import risc_pkg::*;

module risc_instr_decode (
    input  logic [15:0] instr_i,
    output dec_t        dec_o
);

    always_comb begin
        dec_o        = '0;
        dec_o.opcode = instr_i[OPC_LSB +: 4];
        dec_o.ra     = instr_i[RA_LSB +: 3];
        dec_o.rb     = instr_i[RB_LSB +: 3];
        dec_o.rc     = instr_i[RC_LSB +: 3];
        dec_o.comp   = instr_i[COMP_BIT];
        dec_o.cond   = instr_i[COND_LSB +: 2];
        dec_o.imm6   = instr_i[IMM_LSB +: 6];
        // Raw fields are always sliced; only the class decides dest and flags.
        case (op_class(instr_i[OPC_LSB +: 4]))
            CLS_ADI: begin
                dec_o.dest = instr_i[RB_LSB +: 3];
                dec_o.wr_c = 1'b1;
                dec_o.wr_z = 1'b1;
            end
            CLS_ADD: begin
                dec_o.dest      = instr_i[RC_LSB +: 3];
                dec_o.wr_c      = 1'b1;
                dec_o.wr_z      = 1'b1;
                dec_o.use_carry = (instr_i[COND_LSB +: 2] == COND_CARRY);
            end
            CLS_NAND: begin
                dec_o.dest    = instr_i[RC_LSB +: 3];
                dec_o.wr_z    = 1'b1;
                dec_o.illegal = (instr_i[COND_LSB +: 2] == COND_CARRY);
            end
            default: begin
                dec_o.dest = 3'd0;
            end
        endcase
    end

endmodule

// File: rtl/risc_fetch_decode.sv
// rtl/risc_fetch_decode.sv - PC, instruction-memory fetch, 1-entry skid and IF/ID register
import risc_pkg::*;

module risc_fetch_decode #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [15:0]       id_instr,
    output logic [3:0]        id_opcode,
    output logic [2:0]        id_ra,
    output logic [2:0]        id_rb,
    output logic [2:0]        id_rc,
    output logic              id_comp,
    output logic [1:0]        id_cond,
    output logic [5:0]        id_imm6,
    output logic [2:0]        id_dest,
    output logic              id_use_carry,
    output logic              id_wr_c,
    output logic              id_wr_z,
    output logic              id_illegal
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              skid_valid_q, skid_valid_d;
    logic [15:0]       skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic              id_valid_q, id_valid_d;
    logic [ADDR_W-1:0] id_pc_q;
    logic [15:0]       id_instr_q;
    dec_t              id_dec_q;

    logic              consume, ifid_free, load_id, issue;
    logic [15:0]       fill_instr;
    logic [ADDR_W-1:0] fill_pc;
    dec_t              fill_dec;

    assign consume    = id_valid_q && id_ready;
    assign ifid_free  = !id_valid_q || consume;
    // The skid is older than any returning word, so it always refills IF/ID first.
    assign fill_instr = skid_valid_q ? skid_instr_q : imem_rdata;
    assign fill_pc    = skid_valid_q ? skid_pc_q : inflight_pc_q;

    risc_instr_decode u_decode (
        .instr_i (fill_instr),
        .dec_o   (fill_dec)
    );

    always_comb begin
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        id_valid_d   = id_valid_q;
        load_id      = 1'b0;
        if (redirect_valid) begin
            skid_valid_d = 1'b0;
            id_valid_d   = 1'b0;
        end else if (ifid_free) begin
            if (skid_valid_q) begin
                load_id      = 1'b1;
                id_valid_d   = 1'b1;
                skid_valid_d = 1'b0;
            end else if (inflight_q) begin
                load_id    = 1'b1;
                id_valid_d = 1'b1;
            end else begin
                id_valid_d = 1'b0;
            end
        end else if (inflight_q) begin
            skid_valid_d = 1'b1;
            skid_instr_d = imem_rdata;
            skid_pc_d    = inflight_pc_q;
        end
    end

    // A word issued now can always be placed next cycle as long as the skid ends up empty.
    assign issue         = !reset && enable && !redirect_valid && !skid_valid_d;
    assign imem_en       = issue;
    assign imem_addr     = pc_q;
    assign inflight_d    = issue;
    assign inflight_pc_d = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d = pc_q + PC_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            skid_valid_q  <= 1'b0;
            skid_instr_q  <= '0;
            skid_pc_q     <= '0;
            id_valid_q    <= 1'b0;
            id_pc_q       <= '0;
            id_instr_q    <= '0;
            id_dec_q      <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            skid_valid_q  <= skid_valid_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
            id_valid_q    <= id_valid_d;
            if (load_id) begin
                id_pc_q    <= fill_pc;
                id_instr_q <= fill_instr;
                id_dec_q   <= fill_dec;
            end
        end
    end

    assign id_valid     = id_valid_q;
    assign id_pc        = id_pc_q;
    assign id_instr     = id_instr_q;
    assign id_opcode    = id_dec_q.opcode;
    assign id_ra        = id_dec_q.ra;
    assign id_rb        = id_dec_q.rb;
    assign id_rc        = id_dec_q.rc;
    assign id_comp      = id_dec_q.comp;
    assign id_cond      = id_dec_q.cond;
    assign id_imm6      = id_dec_q.imm6;
    assign id_dest      = id_dec_q.dest;
    assign id_use_carry = id_dec_q.use_carry;
    assign id_wr_c      = id_dec_q.wr_c;
    assign id_wr_z      = id_dec_q.wr_z;
    assign id_illegal   = id_dec_q.illegal;

endmodule

// File: tb/tb_risc_fetch_decode.sv
// tb/tb_risc_fetch_decode.sv - decode vector table, hand-built corner sequences and randomized scoreboard run
module tb_risc_fetch_decode;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        imem_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [15:0] id_pc;
    logic [15:0] id_instr;
    logic [3:0]  id_opcode;
    logic [2:0]  id_ra, id_rb, id_rc, id_dest;
    logic        id_comp, id_use_carry, id_wr_c, id_wr_z, id_illegal;
    logic [1:0]  id_cond;
    logic [5:0]  id_imm6;

    risc_fetch_decode dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_opcode      (id_opcode),
        .id_ra          (id_ra),
        .id_rb          (id_rb),
        .id_rc          (id_rc),
        .id_comp        (id_comp),
        .id_cond        (id_cond),
        .id_imm6        (id_imm6),
        .id_dest        (id_dest),
        .id_use_carry   (id_use_carry),
        .id_wr_c        (id_wr_c),
        .id_wr_z        (id_wr_z),
        .id_illegal     (id_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [0:65535];
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    typedef struct {
        logic [15:0] w;
        logic [26:0] exp;
    } tv_t;
    tv_t tbl [10];

    int          nvec, nerr, consumed;
    logic [15:0] exp_pc, fetch_pc;
    logic        prev_hold, post_redirect;
    logic [32:0] prev_word;
    logic [28:0] fields;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference decode written from the instruction-class rules.
    function automatic logic [28:0] model_dec(input logic [15:0] w);
        logic [3:0] op;
        logic [1:0] cond;
        logic [2:0] dest;
        logic       uc, wc, wz, il;
        op = w[15:12]; cond = w[1:0];
        dest = 3'd0; uc = 1'b0; wc = 1'b0; wz = 1'b0; il = 1'b0;
        if (op == 4'd0) begin
            dest = w[8:6]; wc = 1'b1; wz = 1'b1;
        end else if (op == 4'd1) begin
            dest = w[5:3]; wc = 1'b1; wz = 1'b1; uc = (cond == 2'b11);
        end else if (op == 4'd2) begin
            dest = w[5:3]; wz = 1'b1; il = (cond == 2'b11);
        end
        return {op, w[11:9], w[8:6], w[5:3], w[2], w[5:0], dest, uc, wc, wz, il, cond};
    endfunction

    function automatic logic [28:0] act_fields();
        return {id_opcode, id_ra, id_rb, id_rc, id_comp, id_imm6, id_dest,
                id_use_carry, id_wr_c, id_wr_z, id_illegal, id_cond};
    endfunction

    task automatic observe();
        if (reset) begin
            chk("reset_id_valid", id_valid, 1'b0);
            chk("reset_imem_en", imem_en, 1'b0);
            exp_pc = 16'h0000; fetch_pc = 16'h0000;
            prev_hold = 1'b0; post_redirect = 1'b0;
            return;
        end
        if (!enable || redirect_valid) chk("no_issue", imem_en, 1'b0);
        if (imem_en) begin
            chk("fetch_addr", imem_addr, fetch_pc);
            fetch_pc = fetch_pc + 16'd1;
        end
        if (post_redirect) chk("redirect_flush", id_valid, 1'b0);
        if (prev_hold) chk("stall_hold", {id_valid, id_pc, id_instr}, prev_word);
        if (id_valid) begin
            chk("id_pc_order", id_pc, exp_pc);
            chk("id_instr", id_instr, mem[id_pc]);
            chk("id_decode", act_fields(), model_dec(id_instr));
            if (id_ready) begin
                exp_pc = exp_pc + 16'd1;
                consumed++;
            end
        end
        prev_hold     = id_valid && !id_ready && !redirect_valid;
        prev_word     = {1'b1, id_pc, id_instr};
        post_redirect = redirect_valid;
        if (redirect_valid) begin
            exp_pc = redirect_pc; fetch_pc = redirect_pc;
        end
    endtask

    task automatic end_cyc();
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        #1;
        end_cyc();
    endtask

    initial begin
        nvec = 0; nerr = 0; consumed = 0;
        exp_pc = 0; fetch_pc = 0; prev_hold = 0; post_redirect = 0; prev_word = '0;
        tbl[0] = '{16'h1298, {4'h1, 3'd1, 3'd2, 3'd3, 1'b0, 6'h18, 3'd3, 4'b0110}};
        tbl[1] = '{16'h1D2B, {4'h1, 3'd6, 3'd4, 3'd5, 1'b0, 6'h2B, 3'd5, 4'b1110}};
        tbl[2] = '{16'h0881, {4'h0, 3'd4, 3'd2, 3'd0, 1'b0, 6'h01, 3'd2, 4'b0110}};
        tbl[3] = '{16'h2DB4, {4'h2, 3'd6, 3'd6, 3'd6, 1'b1, 6'h34, 3'd6, 4'b0010}};
        tbl[4] = '{16'h2003, {4'h2, 3'd0, 3'd0, 3'd0, 1'b0, 6'h03, 3'd0, 4'b0011}};
        tbl[5] = '{16'h3FFF, {4'h3, 3'd7, 3'd7, 3'd7, 1'b1, 6'h3F, 3'd0, 4'b0000}};
        tbl[6] = '{16'h1003, {4'h1, 3'd0, 3'd0, 3'd0, 1'b0, 6'h03, 3'd0, 4'b1110}};
        tbl[7] = '{16'h0FC5, {4'h0, 3'd7, 3'd7, 3'd0, 1'b1, 6'h05, 3'd7, 4'b0110}};
        tbl[8] = '{16'h2E52, {4'h2, 3'd7, 3'd1, 3'd2, 1'b0, 6'h12, 3'd2, 4'b0010}};
        tbl[9] = '{16'hF000, {4'hF, 3'd0, 3'd0, 3'd0, 1'b0, 6'h00, 3'd0, 4'b0000}};
        for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
        for (int i = 0; i < 10; i++) mem[i] = tbl[i].w;

        reset = 1'b1; enable = 1'b1; id_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 16'h0000;
        cyc();
        #1;
        chk("reset_imem_addr", imem_addr, 16'h0000);
        chk("reset_id_fields", {id_pc, id_instr, act_fields()}, 61'd0);
        end_cyc();

        reset = 1'b0;
        #1;
        chk("first_fetch", {imem_en, imem_addr}, {1'b1, 16'h0000});
        chk("first_not_valid", id_valid, 1'b0);
        end_cyc();
        #1;
        chk("latency_not_valid", id_valid, 1'b0);
        end_cyc();
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("tbl_valid", id_valid, 1'b1);
            chk("tbl_pc", id_pc, 16'(i));
            fields = act_fields();
            chk("tbl_fields", fields[28:2], tbl[i].exp);
            end_cyc();
        end

        id_ready = 1'b0;
        repeat (3) begin
            #1;
            chk("stall_no_issue", imem_en, 1'b0);
            end_cyc();
        end
        id_ready = 1'b1;
        repeat (4) cyc();

        id_ready = 1'b0;
        cyc(); cyc();
        redirect_valid = 1'b1; redirect_pc = 16'h0010;
        cyc();
        redirect_valid = 1'b0; id_ready = 1'b1;
        #1;
        chk("redirect_fetch", {imem_en, imem_addr}, {1'b1, 16'h0010});
        end_cyc();
        cyc();
        #1;
        chk("redirect_first_id", {id_valid, id_pc}, {1'b1, 16'h0010});
        end_cyc();

        redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
        cyc();
        redirect_valid = 1'b0;
        repeat (4) cyc();
        #1;
        chk("pc_wrap", {id_valid, id_pc}, {1'b1, 16'h0000});
        end_cyc();

        enable = 1'b0;
        repeat (2) begin
            #1;
            chk("enable_low", imem_en, 1'b0);
            end_cyc();
        end
        enable = 1'b1;
        cyc();

        reset = 1'b1;
        #1;
        chk("reset_mid_valid", id_valid, 1'b0);
        end_cyc();
        reset = 1'b0;
        #1;
        chk("reset_refetch", {imem_en, imem_addr}, {1'b1, 16'h0000});
        end_cyc();

        consumed = 0;
        for (int n = 0; n < 3000; n++) begin
            reset          = ($urandom_range(0, 599) == 0);
            enable         = ($urandom_range(0, 7) != 0);
            id_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 39) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                                         : 16'($urandom);
            cyc();
        end
        reset = 1'b0; redirect_valid = 1'b0;
        chk("random_progress", (consumed > 300), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
